// File: rtl/ei_tdp_ram_pkg.sv
// Shared types and default sizes for the TDP RAM port-A arbiter front-end.
package ei_tdp_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/ei_rr_arbiter.sv
// Zero-latency round-robin arbiter; the search starts at the pointer and wraps,
// and the pointer moves past the winner whenever a grant is issued.
module ei_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_grant_vld
);

  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_ptr_next;
  logic            w_found;

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && i_valid[ID_W'(j)]) begin
        w_found = 1'b1;
        w_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found && i_enable) o_grant[w_idx] = 1'b1;
  end

  // Explicit wrap keeps the pointer legal when NUM_REQ is not a power of two.
  assign w_ptr_next  = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign o_grant_idx = w_idx;
  assign o_grant_vld = w_found && i_enable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_found && i_enable) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/ei_tdp_ram_port_arb.sv
// Port-A front-end of the TDP RAM: round-robin sharing between requesters,
// tagged read responses, and a clear engine that zeroes the whole array.
module ei_tdp_ram_port_arb
  import ei_tdp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_wdata,
  output logic                           o_rsp_valid,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  input  logic                           i_init_start,
  output logic                           o_init_busy,
  output logic                           o_init_done,
  output logic [ADDR_WIDTH-1:0]          o_ram_addr,
  output logic [DATA_WIDTH-1:0]          o_ram_data,
  output logic                           o_ram_we,
  output logic                           o_ram_re,
  input  logic [DATA_WIDTH-1:0]          i_ram_q
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_next;
  logic                  r_init_done;
  logic                  w_init_done_next;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;

  logic                  w_serve_en;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_grant_vld;
  logic                  w_xfer;
  logic                  w_rd_xfer;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // A pending clear request wins over any grant in the cycle it is seen.
  assign w_serve_en = (r_state == SERVE) && !i_reset && !i_init_start;

  ei_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_req_valid),
    .i_enable    (w_serve_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  assign w_xfer      = w_grant_vld;
  assign w_sel_we    = i_req_we[w_grant_idx];
  assign w_sel_addr  = i_req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = i_req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_rd_xfer   = w_xfer && !w_sel_we;

  always_comb begin
    w_state_next     = r_state;
    w_clr_addr_next  = r_clr_addr;
    w_init_done_next = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_addr_next = r_clr_addr + 1'b1;
        if (&r_clr_addr) begin
          w_state_next     = SERVE;
          w_init_done_next = 1'b1;
        end
      end
      SERVE: begin
        if (i_init_start) begin
          w_state_next    = CLEAR;
          w_clr_addr_next = '0;
        end
      end
      default: begin
        w_state_next    = CLEAR;
        w_clr_addr_next = '0;
      end
    endcase
  end

  // Port-A mux: the clear engine and the granted requester never overlap.
  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_re   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (!i_reset) begin
      if (r_state == CLEAR) begin
        o_ram_we   = 1'b1;
        o_ram_addr = r_clr_addr;
      end else if (w_xfer) begin
        o_ram_addr = w_sel_addr;
        if (w_sel_we) begin
          o_ram_we   = 1'b1;
          o_ram_data = w_sel_wdata;
        end else begin
          o_ram_re = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= CLEAR;
      r_clr_addr  <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_clr_addr  <= w_clr_addr_next;
      r_init_done <= w_init_done_next;
      r_rsp_valid <= w_rd_xfer;
      if (w_rd_xfer) r_rsp_id <= w_grant_idx;
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = i_ram_q;
  assign o_init_busy = (r_state == CLEAR);
  assign o_init_done = r_init_done;

endmodule
